// File: rtl/alu_sort4.sv
// Four-word ascending sorter: a fixed 6-step compare-and-swap network whose
// comparisons are made by an embedded ALU evaluating SUB on each word pair.
module alu_sort4 #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] s0,
    output logic [WIDTH-1:0] s1,
    output logic [WIDTH-1:0] s2,
    output logic [WIDTH-1:0] s3,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    localparam logic [2:0] ALU_ADD = 3'h0;
    localparam logic [2:0] ALU_SUB = 3'h1;
    localparam logic [2:0] ALU_AND = 3'h2;
    localparam logic [2:0] ALU_OR  = 3'h3;
    localparam logic [2:0] ALU_XOR = 3'h4;

    state_t           state;
    logic [2:0]       step;
    logic [WIDTH-1:0] r0, r1, r2, r3;
    logic [WIDTH-1:0] r0_n, r1_n, r2_n, r3_n;

    logic [2:0]       m;
    logic [WIDTH-1:0] a, b, y;
    logic             zf, cf, of;
    logic [1:0]       idx;
    logic             gt;
    logic [WIDTH-1:0] lo, hi;

    assign m = ALU_SUB;

    // ALU responder; for SUB, cf is the borrow (set when a < b unsigned)
    always_comb begin
        y  = '0;
        cf = 1'b0;
        of = 1'b0;
        case (m)
            ALU_ADD: begin
                {cf, y} = {1'b0, a} + {1'b0, b};
                of      = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                {cf, y} = {1'b0, a} - {1'b0, b};
                of      = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            default: y = a;
        endcase
        zf = (y == '0);
    end

    // Network pairs: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1)
    always_comb begin
        case (step)
            3'd0:    idx = 2'd0;
            3'd1:    idx = 2'd1;
            3'd2:    idx = 2'd2;
            3'd3:    idx = 2'd0;
            3'd4:    idx = 2'd1;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        a = r0;
        b = r1;
        case (idx)
            2'd1:    begin a = r1; b = r2; end
            2'd2:    begin a = r2; b = r3; end
            default: begin a = r0; b = r1; end
        endcase
    end

    // Equal operands give zf=1, so they never swap
    assign gt = SIGNED ? (~(y[WIDTH-1] ^ of) & ~zf) : (~cf & ~zf);
    assign lo = gt ? b : a;
    assign hi = gt ? a : b;

    always_comb begin
        r0_n = r0;
        r1_n = r1;
        r2_n = r2;
        r3_n = r3;
        case (idx)
            2'd1:    begin r1_n = lo; r2_n = hi; end
            2'd2:    begin r2_n = lo; r3_n = hi; end
            default: begin r0_n = lo; r1_n = hi; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= 3'd0;
            r0    <= '0;
            r1    <= '0;
            r2    <= '0;
            r3    <= '0;
            s0    <= '0;
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r0    <= x0;
                        r1    <= x1;
                        r2    <= x2;
                        r3    <= x3;
                        step  <= 3'd0;
                        busy  <= 1'b1;
                        state <= SORT;
                    end
                end
                SORT: begin
                    r0   <= r0_n;
                    r1   <= r1_n;
                    r2   <= r2_n;
                    r3   <= r3_n;
                    step <= step + 3'd1;
                    if (step == 3'd5) begin
                        s0    <= r0_n;
                        s1    <= r1_n;
                        s2    <= r2_n;
                        s3    <= r3_n;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sort4.sv
// Bench for alu_sort4: unsigned and signed instances share stimulus; sorted
// words are predicted from a table or an insertion-sort model and scoreboarded.
module tb_alu_sort4;
    localparam int WIDTH = 32;
    localparam int W     = 4 * WIDTH;

    typedef struct packed {
        logic [W-1:0] xs;
        logic [W-1:0] eu;
        logic [W-1:0] es;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] x0, x1, x2, x3;
    logic [WIDTH-1:0] s0u, s1u, s2u, s3u, s0s, s1s, s2s, s3s;
    logic             busy_u, done_u, busy_s, done_s;

    logic [W-1:0] exp_u_q[$];
    logic [W-1:0] exp_s_q[$];
    int checks;
    int failures;

    alu_sort4 #(.WIDTH(WIDTH), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .s0(s0u), .s1(s1u), .s2(s2u), .s3(s3u),
        .busy(busy_u), .done(done_u)
    );

    alu_sort4 #(.WIDTH(WIDTH), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .s0(s0s), .s1(s1s), .s2(s2s), .s3(s3s),
        .busy(busy_s), .done(done_s)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_sort(input logic [W-1:0] xs, input bit sgn);
        logic [WIDTH-1:0] v[4];
        logic [WIDTH-1:0] t;
        logic             g;
        for (int i = 0; i < 4; i++) v[i] = xs[W-1-WIDTH*i -: WIDTH];
        for (int i = 1; i < 4; i++) begin
            for (int j = i; j > 0; j--) begin
                g = sgn ? ($signed(v[j-1]) > $signed(v[j])) : (v[j-1] > v[j]);
                if (!g) break;
                t = v[j-1]; v[j-1] = v[j]; v[j] = t;
            end
        end
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic [WIDTH-1:0] pick_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_x(input logic [W-1:0] xs);
        x0 = xs[127:96];
        x1 = xs[95:64];
        x2 = xs[63:32];
        x3 = xs[31:0];
    endtask

    // Driver: called at a negedge; accepts on the next posedge and waits for done.
    task automatic run_sort(input string name, input logic [W-1:0] xs,
                            input logic [W-1:0] eu, input logic [W-1:0] es, input bit inject);
        int lat;
        logic [W-1:0] pu, ps;
        drive_x(xs);
        start = 1'b1;
        exp_u_q.push_back(eu);
        exp_s_q.push_back(es);
        @(negedge clk);
        start = 1'b0;
        check({name, " busy_u"}, W'(busy_u), W'(1));
        check({name, " busy_s"}, W'(busy_s), W'(1));
        check({name, " done_early"}, W'(done_u | done_s), W'(0));
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (inject) begin
                if (lat == 2) begin
                    start = 1'b1;
                    drive_x(~xs);
                end else begin
                    start = 1'b0;
                end
            end
            if (done_u || done_s) break;
        end
        start = 1'b0;
        check({name, " latency"}, W'(lat), W'(6));
        check({name, " done_u"}, W'(done_u), W'(1));
        check({name, " done_s"}, W'(done_s), W'(1));
        check({name, " busy_after"}, W'(busy_u | busy_s), W'(0));
        pu = '0;
        ps = '0;
        if (exp_u_q.size() > 0 && exp_s_q.size() > 0) begin
            pu = exp_u_q.pop_front();
            ps = exp_s_q.pop_front();
            check({name, " s_unsigned"}, {s0u, s1u, s2u, s3u}, pu);
            check({name, " s_signed"}, {s0s, s1s, s2s, s3s}, ps);
        end else begin
            failures++;
            $display("FAIL %s: scoreboard queue empty at done", name);
        end
        @(negedge clk);
        check({name, " done_pulse"}, W'(done_u | done_s), W'(0));
        check({name, " hold_u"}, {s0u, s1u, s2u, s3u}, pu);
        check({name, " hold_s"}, {s0s, s1s, s2s, s3s}, ps);
    endtask

    vec_t tbl[6];

    initial begin
        logic [W-1:0] rx;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        drive_x('0);

        tbl[0] = '{xs: {32'd4, 32'd3, 32'd2, 32'd1},
                   eu: {32'd1, 32'd2, 32'd3, 32'd4},
                   es: {32'd1, 32'd2, 32'd3, 32'd4}};
        tbl[1] = '{xs: {32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h1},
                   eu: {32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFF},
                   es: {32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h1}};
        tbl[2] = '{xs: {32'h7FFFFFFF, 32'h80000000, 32'h0, 32'hFFFFFFFF},
                   eu: {32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF},
                   es: {32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF}};
        tbl[3] = '{xs: {32'd5, 32'd5, 32'd5, 32'd5},
                   eu: {32'd5, 32'd5, 32'd5, 32'd5},
                   es: {32'd5, 32'd5, 32'd5, 32'd5}};
        tbl[4] = '{xs: {32'd1, 32'd2, 32'd3, 32'd4},
                   eu: {32'd1, 32'd2, 32'd3, 32'd4},
                   es: {32'd1, 32'd2, 32'd3, 32'd4}};
        tbl[5] = '{xs: {32'd2, 32'hFFFFFFFE, 32'd2, 32'h80000001},
                   eu: {32'd2, 32'd2, 32'h80000001, 32'hFFFFFFFE},
                   es: {32'h80000001, 32'hFFFFFFFE, 32'd2, 32'd2}};

        repeat (2) @(negedge clk);
        check("reset s_u", {s0u, s1u, s2u, s3u}, '0);
        check("reset s_s", {s0s, s1s, s2s, s3s}, '0);
        check("reset busy", W'(busy_u | busy_s), W'(0));
        check("reset done", W'(done_u | done_s), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_sort($sformatf("vec%0d", i), tbl[i].xs, tbl[i].eu, tbl[i].es, 1'b0);

        for (int i = 0; i < 8; i++) begin
            rx = {pick_word(), pick_word(), pick_word(), pick_word()};
            run_sort($sformatf("rand%0d", i), rx, model_sort(rx, 1'b0), model_sort(rx, 1'b1), 1'b0);
        end

        // start pulsed with different data at step 2 must not disturb the sort
        run_sort("ignore_start", {32'd40, 32'd10, 32'd30, 32'd20},
                 {32'd10, 32'd20, 32'd30, 32'd40}, {32'd10, 32'd20, 32'd30, 32'd40}, 1'b1);

        // reset asserted at step 3 abandons the sort
        drive_x({32'd8, 32'd3, 32'd6, 32'd1});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort s_u", {s0u, s1u, s2u, s3u}, '0);
        check("abort s_s", {s0s, s1s, s2s, s3s}, '0);
        check("abort busy", W'(busy_u | busy_s), W'(0));
        check("abort done", W'(done_u | done_s), W'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort no_done%0d", i), W'(done_u | done_s), W'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_sort("after_reset", {32'd9, 32'd7, 32'd8, 32'd6},
                 {32'd6, 32'd7, 32'd8, 32'd9}, {32'd6, 32'd7, 32'd8, 32'd9}, 1'b0);

        check("queue_empty", W'(exp_u_q.size() + exp_s_q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
